// File: rtl/sprite_reg_writer.sv
// Sprite register bank write controller: buffers update commands in a FIFO,
// range-checks and packs them, and writes only while the bank is free (compare high).
module sprite_reg_writer #(
    parameter int SIZE_REG   = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [9:0]          cmd_x,
    input  logic [9:0]          cmd_y,
    input  logic [8:0]          cmd_offset,
    input  logic                cmd_enable,
    input  logic                compare,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SIZE_REG-1:0] wr_data,
    output logic                err_pulse,
    output logic [7:0]          err_count,
    output logic                busy
);

    localparam int         PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         ENT_W = ADDR_W + SIZE_REG;
    localparam logic [9:0] X_LIM = 10'(X_MAX);
    localparam logic [9:0] Y_LIM = 10'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } state_t;

    state_t              state;
    logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W:0]      count;
    logic                push;
    logic                pop;
    logic [SIZE_REG-1:0] rec_in;
    logic [ADDR_W-1:0]   hold_addr;
    logic [SIZE_REG-1:0] hold_data;
    logic                out_of_range;

    assign cmd_ready = (count != (PTR_W+1)'(FIFO_DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign rec_in    = SIZE_REG'({2'b00, cmd_enable, cmd_x, cmd_y, cmd_offset});

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_addr, rec_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Disable commands carry no meaningful position, so only enabled ones are range-checked.
    assign out_of_range = hold_data[29] &&
                          ((hold_data[28:19] > X_LIM) || (hold_data[18:9] > Y_LIM));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold_addr <= '0;
            hold_data <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        {hold_addr, hold_data} <= fifo_mem[rd_ptr];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (out_of_range) begin
                        err_pulse <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (compare) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe follows compare directly so the write lands in the first free cycle.
    assign wr_en   = (state == ARMED) & compare;
    assign wr_addr = hold_addr;
    assign wr_data = hold_data;
    assign busy    = (count != '0) || (state != IDLE);

endmodule
